enc: RTL

ENC -- requirements
Module: enc

---
 rtl/def.sv | 26 ++
 rtl/enc_pkg.sv | 43 ++++
 rtl/enc_if.sv | 33 +++
 rtl/enc_pack.sv | 56 +++++
 rtl/enc.sv | 136 +++++++++++++
 5 files changed

// File: rtl/def.sv
// Shared opcode package: RV32I major opcodes (opcode[6:2]) and the
// encoder request kinds used by everything that builds instruction words.
package gopcode;

    typedef enum logic [2:0] {
        K_R  = 3'd0,
        K_I  = 3'd1,
        K_S  = 3'd2,
        K_B  = 3'd3,
        K_U  = 3'd4,
        K_J  = 3'd5,
        K_LI = 3'd6
    } enc_kind_e;

    localparam logic [4:0] SOP_LOAD   = 5'b00000;
    localparam logic [4:0] SOP_OP_IMM = 5'b00100;
    localparam logic [4:0] SOP_AUIPC  = 5'b00101;
    localparam logic [4:0] SOP_STORE  = 5'b01000;
    localparam logic [4:0] SOP_OP     = 5'b01100;
    localparam logic [4:0] SOP_LUI    = 5'b01101;
    localparam logic [4:0] SOP_BRANCH = 5'b11000;
    localparam logic [4:0] SOP_JALR   = 5'b11001;
    localparam logic [4:0] SOP_JAL    = 5'b11011;
    localparam logic [4:0] SOP_SYSTEM = 5'b11100;

endpackage

// File: rtl/enc_pkg.sv
// Encoder-local types and helpers: FSM states, the packer request bundle,
// opcode widening and signed-range checks on 32-bit immediates.
package enc_pkg;

    import gopcode::*;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT1 = 2'd1,
        S_EMIT2 = 2'd2
    } enc_state_e;

    typedef struct packed {
        enc_kind_e   kind;
        logic [4:0]  sop;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } pack_req_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic logic [6:0] full_opcode(input logic [4:0] sop);
        return {sop, 2'b11};
    endfunction

    // A value fits N signed bits when every bit from N-1 upward agrees.
    function automatic logic fits_s12(input logic [31:0] v);
        return (&v[31:11]) || !(|v[31:11]);
    endfunction

    function automatic logic fits_s13(input logic [31:0] v);
        return (&v[31:12]) || !(|v[31:12]);
    endfunction

    function automatic logic fits_s21(input logic [31:0] v);
        return (&v[31:20]) || !(|v[31:20]);
    endfunction

endpackage

// File: rtl/enc_if.sv
// Encoder bus: request side (in_*) and instruction-word side (out_*).
// slave = encoder, master = requester/consumer.
interface enc_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_sopcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        out_err;

    modport slave (
        input  in_valid, in_kind, in_sopcode, in_funct3, in_funct7,
        input  in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_last, out_err
    );

    modport master (
        output in_valid, in_kind, in_sopcode, in_funct3, in_funct7,
        output in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_last, out_err
    );

endinterface

// File: rtl/enc_pack.sv
// Combinational RV32I field packer for R/I/S/B/U/J kinds.
// Ports: req (request bundle) -> word (encoded instr), err (imm not encodable).
module enc_pack
    import gopcode::*;
    import enc_pkg::*;
(
    input  pack_req_t   req,
    output logic [31:0] word,
    output logic        err
);

    logic [6:0]  op;
    logic [31:0] imm;

    always_comb begin
        op   = full_opcode(req.sop);
        imm  = req.imm;
        word = NOP_WORD;
        err  = 1'b1;
        unique case (1'b1)
            req.kind == K_R: begin
                word = {req.funct7, req.rs2, req.rs1,
                        req.funct3, req.rd, op};
                err  = 1'b0;
            end
            req.kind == K_I: begin
                word = {imm[11:0], req.rs1, req.funct3, req.rd, op};
                err  = !fits_s12(imm);
            end
            req.kind == K_S: begin
                word = {imm[11:5], req.rs2, req.rs1,
                        req.funct3, imm[4:0], op};
                err  = !fits_s12(imm);
            end
            req.kind == K_B: begin
                word = {imm[12], imm[10:5], req.rs2, req.rs1,
                        req.funct3, imm[4:1], imm[11], op};
                err  = !fits_s13(imm) || imm[0];
            end
            req.kind == K_U: begin
                word = {imm[31:12], req.rd, op};
                err  = 1'b0;
            end
            req.kind == K_J: begin
                word = {imm[20], imm[10:1], imm[11],
                        imm[19:12], req.rd, op};
                err  = !fits_s21(imm) || imm[0];
            end
            default: begin
                word = NOP_WORD;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/enc.sv
// RV32I instruction encoder: registers a request, emits one or two words
// (LI expands to LUI[+ADDI]) over a valid/ready output with 1-cycle latency.
// Ports: clk, rst_n (async active-low), bus (enc_if.slave).
module enc
    import gopcode::*;
    import enc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    enc_if.slave  bus
);

    enc_state_e  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] word2_q, word2_d;
    logic        last_q, last_d;
    logic        err_q, err_d;

    logic        out_valid;
    logic        in_ready;
    logic        accept;
    logic        hs;

    enc_kind_e   kind;
    logic        li_small;
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic        li_two;
    logic [31:0] addi2;

    pack_req_t   preq;
    logic [31:0] pword;
    logic        perr;

    // LI split: hi rounds so that sign-extended lo added back gives imm.
    always_comb begin
        kind     = enc_kind_e'(bus.in_kind);
        li_small = fits_s12(bus.in_imm);
        li_hi    = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};
        li_lo    = bus.in_imm[11:0];
        li_two   = (kind == K_LI) && !li_small && (li_lo != 12'd0);
        addi2    = {li_lo, bus.in_rd, 3'b000, bus.in_rd,
                    full_opcode(SOP_OP_IMM)};

        preq.kind   = kind;
        preq.sop    = bus.in_sopcode;
        preq.funct3 = bus.in_funct3;
        preq.funct7 = bus.in_funct7;
        preq.rd     = bus.in_rd;
        preq.rs1    = bus.in_rs1;
        preq.rs2    = bus.in_rs2;
        preq.imm    = bus.in_imm;

        // LI reuses the packer as ADDI rd,x0,imm or LUI rd,hi.
        if (kind == K_LI) begin
            preq.funct3 = 3'b000;
            if (li_small) begin
                preq.kind = K_I;
                preq.sop  = SOP_OP_IMM;
                preq.rs1  = 5'd0;
            end else begin
                preq.kind = K_U;
                preq.sop  = SOP_LUI;
                preq.imm  = {li_hi, 12'd0};
            end
        end
    end

    enc_pack u_pack (
        .req  (preq),
        .word (pword),
        .err  (perr)
    );

    always_comb begin
        out_valid = (state_q != S_IDLE);
        hs        = out_valid && bus.out_ready;
        in_ready  = !out_valid || (bus.out_ready && last_q);
        accept    = bus.in_valid && in_ready;

        state_d = state_q;
        instr_d = instr_q;
        word2_d = word2_q;
        last_d  = last_q;
        err_d   = err_q;

        unique case (state_q)
            S_EMIT1: begin
                if (hs && !last_q) begin
                    state_d = S_EMIT2;
                    instr_d = word2_q;
                    last_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            default: ;
        endcase

        // Last word leaving (or idle): load a new request or go empty.
        if (accept) begin
            state_d = S_EMIT1;
            instr_d = pword;
            err_d   = perr;
            last_d  = !li_two;
            word2_d = addi2;
        end else if (hs && last_q) begin
            state_d = S_IDLE;
            instr_d = 32'd0;
            last_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= 32'd0;
            word2_q <= 32'd0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            word2_q <= word2_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = instr_q;
    assign bus.out_last  = last_q;
    assign bus.out_err   = err_q;

endmodule
